axi_slave_mem: RTL and testbench
================================

Name: axi_slave_mem

Overview:
AXI4 slave memory that sits directly downstream of the team's AXI master block and services its write and read bursts. It accepts AW/W and returns B on the write path. It accepts AR and returns R beats on the read path. The two paths run as independent FSMs over a shared word-addressed RAM. It is the endpoint the master's testbench connects to in place of a behavioural memory.

Parameters:
ADDR_W, 32, address width on AWADDR/ARADDR
DATA_W, 32, data width; beats are always full-width (size = log2(DATA_W/8))
ID_W, 4, transaction ID width
MEM_DEPTH, 256, RAM words; must be a power of 2
MAX_BEATS, 16, longest accepted burst (len+1)

Ports:
aclk  in  1  clock; all logic rising-edge
areset  in  1  asynchronous, active-low reset
awid/awaddr/awlen  in  ID_W/ADDR_W/8  write address channel
awvalid/awready  in/out  1/1  AW handshake
wdata/wstrb/wlast  in  DATA_W/DATA_W/8/1  write data channel
wvalid/wready  in/out  1/1  W handshake
bid/bresp  out  ID_W/2  write response
bvalid/bready  out/in  1/1  B handshake
arid/araddr/arlen  in  ID_W/ADDR_W/8  read address channel
arvalid/arready  in/out  1/1  AR handshake
rid/rdata/rresp/rlast  out  ID_W/DATA_W/2/1  read data channel
rvalid/rready  out/in  1/1  R handshake

Behaviour:
- Reset (areset low, async): both FSMs go to IDLE. awready=1, arready=1. wready, bvalid, rvalid and rlast are 0; bresp, rresp, bid, rid and rdata are 0. RAM contents are not reset.
- Word index = addr[log2(DEPTH)+log2(DATA_W/8)-1 : log2(DATA_W/8)]. Low byte-offset bits are ignored. The index wraps modulo MEM_DEPTH. Burst type is always INCR.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: awready=1. On awvalid&awready, latch id/index/len, set beat counter to 0 and the error flag to (awlen+1 > MAX_BEATS). Go to W_DATA. awready drops the next cycle.
  - W_DATA: wready=1. On each wvalid&wready, if the error flag is clear, write each byte lane whose wstrb bit is set. Then index+1 (wrap) and count+1.
  - wlast early (count<len) or missing (count==len with wlast=0): set the error flag and do no further writes. Early wlast ends the burst. A missing wlast keeps accepting beats without writing until wlast arrives.
  - Normal end of W_DATA: wvalid&wready&wlast -> W_RESP.
  - W_RESP: bvalid=1, bid=latched id, bresp=2'b10 (SLVERR) if the error flag is set, else 2'b00. Hold until bready, then W_IDLE. The earliest bvalid is 1 cycle after the last W beat.
- Read FSM R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: arready=1. On handshake, latch id/index/len, set count to 0 and err=(arlen+1 > MAX_BEATS). Go to R_DATA.
  - R_DATA: rvalid=1, rid=id, rdata=mem[index] (read combinationally from the registered index), rresp = err?2'b10:2'b00, rlast=(count==len).
  - The first rvalid comes 1 cycle after the AR handshake. Beats advance only on rvalid&rready.
  - rdata/rlast/rresp stay stable while rvalid&!rready.
  - After the rlast handshake, go to R_IDLE. An errored burst still returns len+1 beats, with rdata=0.
- Same-word write and read in one cycle: the R beat shows the pre-write value. Later beats see the new value.
- The write and read paths are fully concurrent. Neither blocks the other.
- awlen/arlen = 0: single-beat burst. wlast must be set on that beat and rlast is set on the only beat.
- Throughput: one W beat per cycle, one R beat per cycle.
- Reset mid-burst: the burst is discarded and no B or R is issued. RAM words already written keep their data.

Decomposition:
- Package axi_slave_pkg holds:
  - localparams RESP_OKAY=2'b00 and RESP_SLVERR=2'b10
  - enum wr_state_e {W_IDLE, W_DATA, W_RESP}
  - enum rd_state_e {R_IDLE, R_DATA}
- Sub-module axi_slave_ram holds the byte-enabled RAM. It has one write port (we, windex, wdata, wstrb) and one asynchronous read port (rindex -> rdata). It is instantiated once.

Test Plan:
- Single write then read: AW addr 0x10 len 0, W 0xDEADBEEF strb 4'hF wlast=1, bready=1. Expect bresp=00 one cycle after the W beat. Then AR 0x10 len 0: expect rdata=0xDEADBEEF with rlast=1, rvalid 1 cycle after AR.
- 16-beat INCR burst: write 0x0..0xF at addr 0x20, then read back 16 beats. Expect data 0..15, rlast only on beat 15, rid equal to arid=4'h3.
- Strobes and wrap: write 0xFFFFFFFF to word 255, then write 0x00000000 with strb 4'b0101. Expect read 0xFF00FF00. A 2-beat burst at word 255 lands in words 255 and 0.
- Errors: awlen=16 (17 beats) -> bresp=10 and memory unchanged. wlast on beat 2 of a len=3 burst -> bresp=10 after beat 2. arlen=20 -> 21 beats, all rresp=10.
- Backpressure: hold rready=0 for 5 cycles mid-burst; rdata/rlast stay stable. Hold bready=0 for 3 cycles; bvalid and bresp stay stable, and the next awready appears only after the B handshake.
- Reset mid-burst: pull areset low during beat 4 of 8 of a write. Expect all valids at 0 and awready=1 immediately. A fresh write afterwards completes with OKAY. Words 0..3 keep their written data.

Source files
------------

// File: rtl/axi_slave_mem_pkg.sv
// Shared types for the AXI4 slave memory: response codes, FSM states
// and the burst-length check used by both address channels.
package axi_slave_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_e;

  function automatic logic burst_too_long(
    input logic [7:0] len,
    input int         max_beats
  );
    return (int'(len) + 1) > max_beats;
  endfunction

endpackage

// File: rtl/axi_slave_mem_if.sv
// AXI4 subset bus (AW/W/B/AR/R, INCR full-width bursts).
// slave modport faces the memory, master modport faces the requester.
interface axi_slave_mem_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);

  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic                arvalid;
  logic                arready;

  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport slave (
    input  awid, awaddr, awlen, awvalid,
    input  wdata, wstrb, wlast, wvalid,
    input  bready,
    input  arid, araddr, arlen, arvalid,
    input  rready,
    output awready, wready,
    output bid, bresp, bvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid
  );

  modport master (
    output awid, awaddr, awlen, awvalid,
    output wdata, wstrb, wlast, wvalid,
    output bready,
    output arid, araddr, arlen, arvalid,
    output rready,
    input  awready, wready,
    input  bid, bresp, bvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid
  );

endinterface

// File: rtl/axi_slave_ram.sv
// Byte-enabled word RAM: one synchronous write port (we/windex/wdata/wstrb)
// and one asynchronous read port (rindex -> rdata). Contents are not reset.
module axi_slave_ram
  import axi_slave_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 256,
  parameter int IDX_W     = $clog2(MEM_DEPTH)
) (
  input  logic                clk,
  input  logic                we,
  input  logic [IDX_W-1:0]    windex,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic [IDX_W-1:0]    rindex,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (wstrb[b]) begin
          mem[windex][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // Read sees the pre-write word when both ports hit it in one cycle.
  assign rdata = mem[rindex];

endmodule

// File: rtl/axi_slave_mem.sv
// AXI4 slave memory: independent write (AW/W/B) and read (AR/R) FSMs
// over one shared RAM. Ports: aclk, areset (async, active low), bus.
module axi_slave_mem
  import axi_slave_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 4,
  parameter int MEM_DEPTH = 256,
  parameter int MAX_BEATS = 16
) (
  input  logic            aclk,
  input  logic            areset,
  axi_slave_mem_if.slave  bus
);

  localparam int OFF_W = $clog2(DATA_W/8);
  localparam int IDX_W = $clog2(MEM_DEPTH);

  // ---------------- write path ----------------
  wr_state_e         w_state, w_next;
  logic [ID_W-1:0]   w_id;
  logic [IDX_W-1:0]  w_idx;
  logic [7:0]        w_len;
  logic [7:0]        w_cnt;
  logic              w_err;
  logic              aw_hs;
  logic              w_hs;
  logic              w_bad;

  assign aw_hs = (w_state == W_IDLE) && bus.awvalid;
  assign w_hs  = (w_state == W_DATA) && bus.wvalid;

  // Early wlast or a missing wlast on the final counted beat.
  assign w_bad = bus.wlast ? (w_cnt != w_len)
                           : (w_cnt == w_len);

  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) w_state <= W_IDLE;
    else         w_state <= w_next;
  end

  always_comb begin
    w_next      = w_state;
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    bus.bvalid  = 1'b0;
    bus.bresp   = RESP_OKAY;
    unique case (w_state)
      W_IDLE: begin
        bus.awready = 1'b1;
        if (bus.awvalid) w_next = W_DATA;
      end
      W_DATA: begin
        bus.wready = 1'b1;
        if (bus.wvalid && bus.wlast) w_next = W_RESP;
      end
      W_RESP: begin
        bus.bvalid = 1'b1;
        bus.bresp  = w_err ? RESP_SLVERR : RESP_OKAY;
        if (bus.bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      w_id  <= '0;
      w_idx <= '0;
      w_len <= '0;
      w_cnt <= '0;
      w_err <= 1'b0;
    end else if (aw_hs) begin
      w_id  <= bus.awid;
      w_idx <= bus.awaddr[IDX_W+OFF_W-1:OFF_W];
      w_len <= bus.awlen;
      w_cnt <= '0;
      w_err <= burst_too_long(bus.awlen, MAX_BEATS);
    end else if (w_hs) begin
      w_idx <= w_idx + 1'b1;
      w_cnt <= w_cnt + 8'd1;
      if (w_bad) w_err <= 1'b1;
    end
  end

  assign bus.bid = w_id;

  // ---------------- read path ----------------
  rd_state_e         r_state, r_next;
  logic [ID_W-1:0]   r_id;
  logic [IDX_W-1:0]  r_idx;
  logic [7:0]        r_len;
  logic [7:0]        r_cnt;
  logic              r_err;
  logic              ar_hs;
  logic              r_hs;
  logic [DATA_W-1:0] ram_rdata;

  assign ar_hs = (r_state == R_IDLE) && bus.arvalid;
  assign r_hs  = (r_state == R_DATA) && bus.rready;

  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) r_state <= R_IDLE;
    else         r_state <= r_next;
  end

  always_comb begin
    r_next      = r_state;
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rlast   = 1'b0;
    bus.rresp   = RESP_OKAY;
    bus.rdata   = '0;
    unique case (r_state)
      R_IDLE: begin
        bus.arready = 1'b1;
        if (bus.arvalid) r_next = R_DATA;
      end
      R_DATA: begin
        bus.rvalid = 1'b1;
        bus.rlast  = (r_cnt == r_len);
        bus.rresp  = r_err ? RESP_SLVERR : RESP_OKAY;
        bus.rdata  = r_err ? '0 : ram_rdata;
        if (bus.rready && bus.rlast) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      r_id  <= '0;
      r_idx <= '0;
      r_len <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (ar_hs) begin
      r_id  <= bus.arid;
      r_idx <= bus.araddr[IDX_W+OFF_W-1:OFF_W];
      r_len <= bus.arlen;
      r_cnt <= '0;
      r_err <= burst_too_long(bus.arlen, MAX_BEATS);
    end else if (r_hs) begin
      r_idx <= r_idx + 1'b1;
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign bus.rid = r_id;

  // ---------------- storage ----------------
  axi_slave_ram #(
    .DATA_W    (DATA_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_ram (
    .clk    (aclk),
    .we     (w_hs && !w_err),
    .windex (w_idx),
    .wdata  (bus.wdata),
    .wstrb  (bus.wstrb),
    .rindex (r_idx),
    .rdata  (ram_rdata)
  );

  // Address bits outside the word index carry no meaning here.
  logic unused_addr;
  assign unused_addr = ^{bus.awaddr[ADDR_W-1:IDX_W+OFF_W],
                         bus.awaddr[OFF_W-1:0],
                         bus.araddr[ADDR_W-1:IDX_W+OFF_W],
                         bus.araddr[OFF_W-1:0]};

endmodule

// File: tb/tb_axi_slave_mem.sv
// Testbench for axi_slave_mem: randomized bursts checked against a
// word-array model of the memory and the burst/response rules.
module tb_axi_slave_mem;
  import axi_slave_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;
  localparam int DEPTH  = 256;
  localparam int MAXB   = 16;

  logic aclk = 1'b0;
  logic areset = 1'b0;
  always #5 aclk = ~aclk;

  axi_slave_mem_if #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .ID_W   (ID_W)
  ) bus ();

  axi_slave_mem #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .ID_W      (ID_W),
    .MEM_DEPTH (DEPTH),
    .MAX_BEATS (MAXB)
  ) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  int passed = 0;
  int total  = 0;

  logic [31:0] model [DEPTH];
  bit          known [DEPTH];

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_write(
    input  logic [ID_W-1:0] id,
    input  logic [31:0]     addr,
    input  int              len,
    input  logic [31:0]     data[$],
    input  logic [3:0]      strb[$],
    input  int              last_at,
    input  int              bstall,
    input  bit              gaps,
    output logic [1:0]      resp
  );
    bit          err;
    int          idx;
    int          n;
    int          miss;
    logic [1:0]  exp;
    logic [31:0] w;
    err = (len + 1) > MAXB;
    idx = int'(addr[9:2]);
    for (int i = 0; i <= last_at; i++) begin
      if (!err) begin
        w = model[idx];
        for (int b = 0; b < 4; b++)
          if (strb[i][b]) w[8*b +: 8] = data[i][8*b +: 8];
        model[idx] = w;
        known[idx] = known[idx] || (strb[i] == 4'hF);
      end
      if (i == last_at && i < len) begin
        err = 1'b1;
        known[idx] = 1'b0;
      end
      idx = (idx + 1) % DEPTH;
    end
    exp = err ? RESP_SLVERR : RESP_OKAY;

    bus.awid    = id;
    bus.awaddr  = addr;
    bus.awlen   = 8'(len);
    bus.awvalid = 1'b1;
    n = 0;
    while (bus.awready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (n >= 20) $display("FAIL aw_accept got timeout need awready=1");
    else passed++;
    tick();
    bus.awvalid = 1'b0;

    miss = 0;
    for (int i = 0; i <= last_at; i++) begin
      if (gaps && $urandom_range(3) == 0) begin
        bus.wvalid = 1'b0;
        tick();
      end
      bus.wvalid = 1'b1;
      bus.wdata  = data[i];
      bus.wstrb  = strb[i];
      bus.wlast  = (i == last_at);
      if (bus.wready !== 1'b1) miss++;
      tick();
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
    total++;
    if (miss != 0) $display("FAIL wready got %0d low beats need 0", miss);
    else passed++;

    total++;
    if (bus.bvalid !== 1'b1) $display("FAIL b_latency bvalid got %b need 1", bus.bvalid);
    else passed++;
    total++;
    if (bus.bid !== id) $display("FAIL bid got %h need %h", bus.bid, id);
    else passed++;
    total++;
    if (bus.bresp !== exp) $display("FAIL bresp got %b need %b", bus.bresp, exp);
    else passed++;

    for (int s = 0; s < bstall; s++) begin
      tick();
      total++;
      if (bus.bvalid !== 1'b1 || bus.bresp !== exp || bus.awready !== 1'b0)
        $display("FAIL b_hold got v=%b r=%b aw=%b need 1 %b 0",
                 bus.bvalid, bus.bresp, bus.awready, exp);
      else passed++;
    end
    resp = bus.bresp;
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    total++;
    if (bus.bvalid !== 1'b0 || bus.awready !== 1'b1)
      $display("FAIL b_done got bvalid=%b awready=%b need 0 1", bus.bvalid, bus.awready);
    else passed++;
  endtask

  task automatic do_read(
    input logic [ID_W-1:0] id,
    input logic [31:0]     addr,
    input int              len,
    input int              stall_at,
    input int              stall_n,
    input bit              gaps
  );
    bit          err;
    int          idx;
    int          n;
    int          ns;
    logic [31:0] snap_d;
    logic        snap_l;
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    err   = (len + 1) > MAXB;
    idx   = int'(addr[9:2]);
    exp_r = err ? RESP_SLVERR : RESP_OKAY;

    bus.arid    = id;
    bus.araddr  = addr;
    bus.arlen   = 8'(len);
    bus.arvalid = 1'b1;
    n = 0;
    while (bus.arready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (n >= 20) $display("FAIL ar_accept got timeout need arready=1");
    else passed++;
    tick();
    bus.arvalid = 1'b0;
    total++;
    if (bus.rvalid !== 1'b1) $display("FAIL r_latency rvalid got %b need 1", bus.rvalid);
    else passed++;

    for (int i = 0; i <= len; i++) begin
      n = 0;
      while (bus.rvalid !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      if (n >= 20) begin
        total++;
        $display("FAIL r_beat %0d got timeout need rvalid=1", i);
        break;
      end
      if (i == stall_at || (gaps && $urandom_range(2) == 0)) begin
        snap_d = bus.rdata;
        snap_l = bus.rlast;
        ns = (i == stall_at) ? stall_n : 1;
        for (int s = 0; s < ns; s++) begin
          tick();
          total++;
          if (bus.rvalid !== 1'b1 || bus.rdata !== snap_d || bus.rlast !== snap_l)
            $display("FAIL r_hold got v=%b d=%h l=%b need 1 %h %b",
                     bus.rvalid, bus.rdata, bus.rlast, snap_d, snap_l);
          else passed++;
        end
      end
      exp_d = err ? 32'h0 : model[idx];
      if (err || known[idx]) begin
        total++;
        if (bus.rdata !== exp_d)
          $display("FAIL rdata beat %0d got %h need %h", i, bus.rdata, exp_d);
        else passed++;
      end
      total++;
      if (bus.rlast !== (i == len))
        $display("FAIL rlast beat %0d got %b need %b", i, bus.rlast, (i == len));
      else passed++;
      total++;
      if (bus.rresp !== exp_r)
        $display("FAIL rresp beat %0d got %b need %b", i, bus.rresp, exp_r);
      else passed++;
      total++;
      if (bus.rid !== id) $display("FAIL rid got %h need %h", bus.rid, id);
      else passed++;
      bus.rready = 1'b1;
      tick();
      bus.rready = 1'b0;
      idx = (idx + 1) % DEPTH;
    end
    total++;
    if (bus.rvalid !== 1'b0 || bus.arready !== 1'b1)
      $display("FAIL r_done got rvalid=%b arready=%b need 0 1", bus.rvalid, bus.arready);
    else passed++;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if (bus.awready !== 1'b1 || bus.arready !== 1'b1)
      $display("FAIL rst_ready got aw=%b ar=%b need 1 1", bus.awready, bus.arready);
    else passed++;
    total++;
    if (bus.wready !== 1'b0 || bus.bvalid !== 1'b0 || bus.rvalid !== 1'b0 || bus.rlast !== 1'b0)
      $display("FAIL rst_valid got w=%b b=%b r=%b l=%b need 0",
               bus.wready, bus.bvalid, bus.rvalid, bus.rlast);
    else passed++;
    total++;
    if (bus.bresp !== 2'b00 || bus.rresp !== 2'b00 || bus.bid !== '0 || bus.rid !== '0)
      $display("FAIL rst_resp got %b %b %h %h need 0", bus.bresp, bus.rresp, bus.bid, bus.rid);
    else passed++;
    total++;
    if (bus.rdata !== 32'h0) $display("FAIL rst_rdata got %h need 0", bus.rdata);
    else passed++;
    @(posedge aclk);
    #1 areset = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [31:0] d[$];
    logic [3:0]  s[$];
    logic [1:0]  r;
    d = '{32'hDEADBEEF};
    s = '{4'hF};
    do_write(4'h1, 32'h10, 0, d, s, 0, 0, 0, r);
    do_read(4'h2, 32'h10, 0, -1, 0, 0);
  endtask

  task automatic test_burst16();
    logic [31:0] d[$];
    logic [3:0]  s[$];
    logic [1:0]  r;
    for (int i = 0; i < 16; i++) begin
      d.push_back(32'(i));
      s.push_back(4'hF);
    end
    do_write(4'h3, 32'h20, 15, d, s, 15, 0, 1, r);
    do_read(4'h3, 32'h20, 15, -1, 0, 0);
  endtask

  task automatic test_strobe_wrap();
    logic [31:0] d[$];
    logic [3:0]  s[$];
    logic [1:0]  r;
    d = '{32'hFFFFFFFF};
    s = '{4'hF};
    do_write(4'h4, 32'h3FC, 0, d, s, 0, 0, 0, r);
    d = '{32'h00000000};
    s = '{4'b0101};
    do_write(4'h4, 32'h3FC, 0, d, s, 0, 0, 0, r);
    do_read(4'h4, 32'h3FC, 0, -1, 0, 0);
    total++;
    if (model[255] !== 32'hFF00FF00 || !known[255])
      $display("FAIL strobe_model got %h need ff00ff00", model[255]);
    else passed++;
    d = '{32'hA5A5_0001, 32'h5A5A_0002};
    s = '{4'hF, 4'hF};
    do_write(4'h5, 32'h3FD, 1, d, s, 1, 0, 0, r);
    do_read(4'h6, 32'h3FC, 0, -1, 0, 0);
    do_read(4'h6, 32'h000, 0, -1, 0, 0);
  endtask

  task automatic test_errors();
    logic [31:0] d[$];
    logic [3:0]  s[$];
    logic [1:0]  r;
    for (int i = 0; i < 16; i++) begin
      d.push_back($urandom);
      s.push_back(4'hF);
    end
    do_write(4'h7, 32'h100, 15, d, s, 15, 0, 0, r);
    d.delete();
    s.delete();
    for (int i = 0; i < 17; i++) begin
      d.push_back($urandom);
      s.push_back(4'hF);
    end
    do_write(4'h8, 32'h100, 16, d, s, 16, 0, 0, r);
    total++;
    if (r !== RESP_SLVERR) $display("FAIL too_long bresp got %b need 10", r);
    else passed++;
    do_read(4'h9, 32'h100, 15, -1, 0, 0);
    d.delete();
    s.delete();
    for (int i = 0; i < 2; i++) begin
      d.push_back($urandom);
      s.push_back(4'hF);
    end
    do_write(4'hA, 32'h200, 3, d, s, 1, 0, 0, r);
    total++;
    if (r !== RESP_SLVERR) $display("FAIL early_last bresp got %b need 10", r);
    else passed++;
    do_read(4'hB, 32'h300, 20, -1, 0, 0);
  endtask

  task automatic test_backpressure();
    logic [31:0] d[$];
    logic [3:0]  s[$];
    logic [1:0]  r;
    for (int i = 0; i < 8; i++) begin
      d.push_back($urandom);
      s.push_back(4'hF);
    end
    do_write(4'hC, 32'h60, 7, d, s, 7, 3, 0, r);
    do_read(4'hD, 32'h60, 7, 3, 5, 0);
  endtask

  task automatic test_reset_mid();
    logic [31:0] d[$];
    logic [3:0]  s[$];
    logic [1:0]  r;
    bus.awid    = 4'h1;
    bus.awaddr  = 32'h0;
    bus.awlen   = 8'd7;
    bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.wvalid = 1'b1;
      bus.wdata  = $urandom;
      bus.wstrb  = 4'hF;
      bus.wlast  = 1'b0;
      model[i]   = bus.wdata;
      known[i]   = 1'b1;
      tick();
    end
    bus.wdata = $urandom;
    for (int i = 4; i < 8; i++) known[i] = 1'b0;
    #2 areset = 1'b0;
    #1;
    total++;
    if (bus.awready !== 1'b1 || bus.arready !== 1'b1)
      $display("FAIL mid_rst_ready got aw=%b ar=%b need 1 1", bus.awready, bus.arready);
    else passed++;
    total++;
    if (bus.wready !== 1'b0 || bus.bvalid !== 1'b0 || bus.rvalid !== 1'b0)
      $display("FAIL mid_rst_valid got w=%b b=%b r=%b need 0",
               bus.wready, bus.bvalid, bus.rvalid);
    else passed++;
    bus.wvalid = 1'b0;
    tick();
    areset = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      d.push_back($urandom);
      s.push_back(4'hF);
    end
    do_write(4'h2, 32'h40, 3, d, s, 3, 0, 0, r);
    total++;
    if (r !== RESP_OKAY) $display("FAIL post_rst bresp got %b need 00", r);
    else passed++;
    do_read(4'h3, 32'h0, 3, -1, 0, 0);
  endtask

  task automatic test_concurrent();
    logic [31:0] d[$];
    logic [3:0]  s[$];
    logic [1:0]  r;
    for (int i = 0; i < 8; i++) begin
      d.push_back($urandom);
      s.push_back(4'hF);
    end
    fork
      do_write(4'h5, 32'h280, 7, d, s, 7, 1, 1, r);
      do_read(4'h6, 32'h100, 15, 2, 2, 1);
    join
    do_read(4'h7, 32'h280, 7, -1, 0, 1);
  endtask

  task automatic test_random();
    logic [31:0] d[$];
    logic [3:0]  s[$];
    logic [1:0]  r;
    logic [31:0] a;
    int          len;
    for (int it = 0; it < 6; it++) begin
      d.delete();
      s.delete();
      len = $urandom_range(15);
      a   = {22'h0, 8'($urandom_range(255)), 2'($urandom_range(3))};
      for (int i = 0; i <= len; i++) begin
        d.push_back($urandom);
        s.push_back($urandom_range(1) ? 4'hF : 4'($urandom_range(15)));
      end
      do_write(4'($urandom), a, len, d, s, len, $urandom_range(2), 1, r);
      total++;
      if (r !== RESP_OKAY) $display("FAIL rand_bresp got %b need 00", r);
      else passed++;
      do_read(4'($urandom), a, len, $urandom_range(15), $urandom_range(1, 3), 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout need finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      model[i] = '0;
      known[i] = 1'b0;
    end
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    test_reset();
    test_single();
    test_burst16();
    test_strobe_wrap();
    test_errors();
    test_backpressure();
    test_concurrent();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
